trap_ctrl: RTL
==============

TRAP_CTRL -- requirements
Module: trap_ctrl

Interface
REQ-001 SHALL have port: clk  in  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port: rst_n  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have port: trap_valid  in  1  core raises synchronous exception.
REQ-004 SHALL have port: trap_ready  out  1  high only in IDLE; trap accepted when trap_valid & trap_ready.
REQ-005 SHALL have port: trap_cause  in  5  exception code (2 illegal, 3 ebreak, 11 ecall), zero-extended to 32.
REQ-006 SHALL have port: trap_pc  in  32  PC of faulting instruction.
REQ-007 SHALL have port: trap_tval  in  32  trap value; used only with TRAP_MTVAL_EN.
REQ-008 SHALL have port: mret_valid  in  1  core executes mret.
REQ-009 SHALL have port: mret_ready  out  1  high in IDLE when trap_valid low.
REQ-010 SHALL have port: csr_wr_en  out  1  write strobe to CSR file.
REQ-011 SHALL have port: csr_addr  out  12  CSR address, read and write.
REQ-012 SHALL have port: csr_wdata  out  32  CSR write data.
REQ-013 SHALL have port: csr_rdata  in  32  combinational read of csr_addr, same cycle.
REQ-014 SHALL have port: redirect_valid  out  1  one-cycle pulse, core loads redirect_pc.
REQ-015 SHALL have port: redirect_pc  out  32  next fetch PC.
REQ-016 SHALL have port: busy  out  1  high whenever state != IDLE.

Function
REQ-017 FSM states SHALL be: IDLE, T_MEPC, T_MCAUSE, T_MTVAL (macro only), T_MSTATUS, T_REDIR, R_MSTATUS, R_REDIR.
REQ-018 On trap accept, trap_cause, trap_pc and trap_tval SHALL be registered; IDLE->T_MEPC.
REQ-019 T_MEPC: csr_wr_en=1, csr_addr=0x341, csr_wdata={pc[31:2],2'b00}; ->T_MCAUSE.
REQ-020 T_MCAUSE: write 0x342 = {27'b0,cause}; ->T_MTVAL if macro defined, else ->T_MSTATUS.
REQ-021 T_MSTATUS: csr_addr=0x300; write csr_rdata with bit7 (MPIE)<=bit3 (MIE), bit3<=0, bits[12:11] (MPP)<=2'b11, other bits unchanged; ->T_REDIR.
REQ-022 T_REDIR: csr_addr=0x305, csr_wr_en=0, redirect_valid=1, redirect_pc={csr_rdata[31:2],2'b00} (direct mode only); ->IDLE.
REQ-023 Trap latency: accept in cycle N, redirect_valid in cycle N+4 (N+5 with macro).
REQ-024 On mret accept, IDLE->R_MSTATUS: write 0x300 with bit3<=bit7, bit7<=1, MPP<=2'b11; ->R_REDIR.
REQ-025 R_REDIR: csr_addr=0x341, redirect_valid=1, redirect_pc=csr_rdata; ->IDLE. Latency 2 cycles.
REQ-026 trap_valid and mret_valid high in same IDLE cycle SHALL accept trap only; mret_ready=0.
REQ-027 Requests while busy SHALL be ignored (ready low); the core holds them.
REQ-028 At most one CSR write per cycle; csr_wr_en=0, csr_addr=0, csr_wdata=0, redirect_valid=0 in IDLE.
REQ-029 Back-to-back: new request SHALL be accepted in the cycle immediately after a redirect cycle.

Reset
REQ-030 rst_n low SHALL force IDLE and all outputs to 0, trap_ready=1, mret_ready=1, regardless of clk.
REQ-031 Reset mid-sequence SHALL abandon it; no further CSR write or redirect for that request.

Configuration
REQ-032 Macro TRAP_MTVAL_EN defined: T_MTVAL writes 0x343 = registered trap_tval, one extra cycle. Undefined: state absent, 0x343 never addressed, trap_tval unused.

Structure
REQ-033 Shared package SHALL hold CSR addresses (0x300, 0x305, 0x341, 0x342, 0x343), cause codes, mstatus bit positions, FSM state enum.
REQ-034 No sub-module is required; mstatus update SHALL be a local function.

Verification
REQ-035 ecall, pc=0x8000_0010, mtvec=0x8000_0101, mstatus=0x8 -> writes mepc=0x8000_0010, mcause=0xB, mstatus=0x1880; redirect_pc=0x8000_0100 at N+4.
REQ-036 mret, mepc=0x8000_0014, mstatus=0x1880 -> mstatus=0x1888, redirect_pc=0x8000_0014 at N+2.
REQ-037 trap_valid and mret_valid same cycle -> trap sequence only; mret accepted after redirect.
REQ-038 rst_n low during T_MCAUSE -> no mstatus write, no redirect, trap_ready=1 immediately.
REQ-039 TRAP_MTVAL_EN, illegal (cause 2), tval=0xDEAD_BEEF -> mtval=0xDEAD_BEEF written, redirect at N+5.

Source files
------------

// File: rtl/trap_ctrl_pkg.sv
// Shared definitions for the machine-mode trap/mret sequencer.
// TRAP_MTVAL_EN adds the T_MTVAL state (mtval write) to the trap sequence.
package trap_ctrl_pkg;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MTVAL   = 12'h343;

  localparam logic [4:0] CAUSE_ILLEGAL = 5'd2;
  localparam logic [4:0] CAUSE_EBREAK  = 5'd3;
  localparam logic [4:0] CAUSE_ECALL   = 5'd11;

  localparam int unsigned MSTATUS_MIE    = 3;
  localparam int unsigned MSTATUS_MPIE   = 7;
  localparam int unsigned MSTATUS_MPP_LO = 11;
  localparam int unsigned MSTATUS_MPP_HI = 12;
  localparam logic [1:0]  PRIV_M         = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    T_MEPC,
    T_MCAUSE,
`ifdef TRAP_MTVAL_EN
    T_MTVAL,
`endif
    T_MSTATUS,
    T_REDIR,
    R_MSTATUS,
    R_REDIR
  } state_e;

endpackage

// File: rtl/trap_ctrl.sv
// Trap entry / mret sequencer: walks the machine CSRs one write per cycle, then redirects fetch.
// Optional macro TRAP_MTVAL_EN: also writes mtval with the registered trap value.
module trap_ctrl
  import trap_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        trap_valid,
  output logic        trap_ready,
  input  logic [4:0]  trap_cause,
  input  logic [31:0] trap_pc,
  input  logic [31:0] trap_tval,
  input  logic        mret_valid,
  output logic        mret_ready,
  output logic        csr_wr_en,
  output logic [11:0] csr_addr,
  output logic [31:0] csr_wdata,
  input  logic [31:0] csr_rdata,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        busy
);

  state_e      state_q, state_d;
  logic [4:0]  cause_q, cause_d;
  logic [31:0] pc_q, pc_d;

`ifdef TRAP_MTVAL_EN
  logic [31:0] tval_q, tval_d;
`else
  logic unused_tval;
  assign unused_tval = ^trap_tval;
`endif

  function automatic logic [31:0] mstatus_on_trap(input logic [31:0] ms);
    logic [31:0] r;
    r = ms;
    r[MSTATUS_MPIE] = ms[MSTATUS_MIE];
    r[MSTATUS_MIE]  = 1'b0;
    r[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = PRIV_M;
    return r;
  endfunction

  function automatic logic [31:0] mstatus_on_mret(input logic [31:0] ms);
    logic [31:0] r;
    r = ms;
    r[MSTATUS_MIE]  = ms[MSTATUS_MPIE];
    r[MSTATUS_MPIE] = 1'b1;
    r[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = PRIV_M;
    return r;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cause_q <= '0;
      pc_q    <= '0;
`ifdef TRAP_MTVAL_EN
      tval_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
      pc_q    <= pc_d;
`ifdef TRAP_MTVAL_EN
      tval_q  <= tval_d;
`endif
    end
  end

  always_comb begin
    state_d        = state_q;
    cause_d        = cause_q;
    pc_d           = pc_q;
`ifdef TRAP_MTVAL_EN
    tval_d         = tval_q;
`endif
    trap_ready     = 1'b0;
    mret_ready     = 1'b0;
    csr_wr_en      = 1'b0;
    csr_addr       = '0;
    csr_wdata      = '0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;

    case (state_q)
      IDLE: begin
        trap_ready = 1'b1;
        mret_ready = !trap_valid;
        if (trap_valid) begin
          cause_d = trap_cause;
          pc_d    = trap_pc;
`ifdef TRAP_MTVAL_EN
          tval_d  = trap_tval;
`endif
          state_d = T_MEPC;
        end else if (mret_valid) begin
          state_d = R_MSTATUS;
        end
      end
      T_MEPC: begin
        csr_wr_en = 1'b1;
        csr_addr  = CSR_MEPC;
        csr_wdata = pc_q & 32'hFFFF_FFFC;
        state_d   = T_MCAUSE;
      end
      T_MCAUSE: begin
        csr_wr_en = 1'b1;
        csr_addr  = CSR_MCAUSE;
        csr_wdata = {27'b0, cause_q};
`ifdef TRAP_MTVAL_EN
        state_d   = T_MTVAL;
`else
        state_d   = T_MSTATUS;
`endif
      end
`ifdef TRAP_MTVAL_EN
      T_MTVAL: begin
        csr_wr_en = 1'b1;
        csr_addr  = CSR_MTVAL;
        csr_wdata = tval_q;
        state_d   = T_MSTATUS;
      end
`endif
      T_MSTATUS: begin
        csr_wr_en = 1'b1;
        csr_addr  = CSR_MSTATUS;
        csr_wdata = mstatus_on_trap(csr_rdata);
        state_d   = T_REDIR;
      end
      T_REDIR: begin
        // direct mode only: mtvec mode bits are masked off
        csr_addr       = CSR_MTVEC;
        redirect_valid = 1'b1;
        redirect_pc    = csr_rdata & 32'hFFFF_FFFC;
        state_d        = IDLE;
      end
      R_MSTATUS: begin
        csr_wr_en = 1'b1;
        csr_addr  = CSR_MSTATUS;
        csr_wdata = mstatus_on_mret(csr_rdata);
        state_d   = R_REDIR;
      end
      R_REDIR: begin
        csr_addr       = CSR_MEPC;
        redirect_valid = 1'b1;
        redirect_pc    = csr_rdata;
        state_d        = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // state is already forced to IDLE by reset; mret_ready must also ignore trap_valid then
    if (!rst_n) mret_ready = 1'b1;
  end

  assign busy = (state_q != IDLE);

endmodule
